// File: rtl/datamem_param.sv
`default_nettype none
// ============================================================================
// Module   : datamem_param
// Brief    : Parametrised single-port data memory with req/rdy handshake,
//            byte-lane writes, registered reads and power-on clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module datamem_param #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int DEPTH        = 2**ADDR_W,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_DM,
    input  logic                  we_DM,
    input  logic [ADDR_W-1:0]     addDM,
    input  logic [DATA_W-1:0]     dataDM,
    input  logic [DATA_W/8-1:0]   be_DM,
    output logic                  rdy_DM,
    output logic [DATA_W-1:0]     outDM,
    output logic                  rvalid_DM,
    output logic                  err_DM,
    output logic                  busy_DM
);

    localparam int                c_NB    = DATA_W / 8;
    localparam int                c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DEPTH - 1);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_IDLE = 1'b1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_clrCnt;

    // Request captured at the accept edge, answered one edge later
    logic               r_rdPend;
    logic               r_rdOor;
    logic [c_IDX_W-1:0] r_rdIdx;
    logic               r_wrErr;
    logic [DATA_W-1:0]  r_outDM;
    logic               r_rvalid;
    logic               r_err;

    logic               w_accept;
    logic               w_inRange;
    logic               w_wrAcc;
    logic               w_clrWe;
    logic [c_IDX_W-1:0] w_idx;

    assign rdy_DM    = (r_state == S_IDLE);
    assign busy_DM   = (r_state == S_INIT);
    assign w_accept  = req_DM & rdy_DM;
    assign w_inRange = ({1'b0, addDM} < c_DEPTH);
    assign w_idx     = addDM[c_IDX_W-1:0];
    assign w_wrAcc   = w_accept & we_DM & w_inRange;
    // rst_n gate keeps the sweep from writing while reset is still held
    assign w_clrWe   = (r_state == S_INIT) && (CLEAR_ON_RST != 0) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_INIT;
            r_clrCnt <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if ((CLEAR_ON_RST == 0) || (r_clrCnt == c_LAST)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clrCnt <= r_clrCnt + 1'b1;
                    end
                end
                S_IDLE:  r_state <= S_IDLE;
                default: r_state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_clrWe) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_wrAcc) begin
            for (int i = 0; i < c_NB; i++) begin
                if (be_DM[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dataDM[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPend <= 1'b0;
            r_rdOor  <= 1'b0;
            r_rdIdx  <= '0;
            r_wrErr  <= 1'b0;
        end else if (w_accept) begin
            r_rdPend <= ~we_DM;
            r_rdOor  <= ~w_inRange;
            r_rdIdx  <= w_idx;
            r_wrErr  <= we_DM & ~w_inRange;
        end else begin
            r_rdPend <= 1'b0;
            r_rdOor  <= 1'b0;
            r_wrErr  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outDM  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= r_rdPend;
            r_err    <= (r_rdPend & r_rdOor) | r_wrErr;
            if (r_rdPend) begin
                r_outDM <= r_rdOor ? '0 : r_mem[r_rdIdx];
            end
        end
    end

    assign outDM     = r_outDM;
    assign rvalid_DM = r_rvalid;
    assign err_DM    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_datamem_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_param
// Brief    : Directed self-checking bench for datamem_param (DEPTH=16, ADDR_W=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              req_DM = 1'b0;
    logic              we_DM  = 1'b0;
    logic [ADDR_W-1:0] addDM  = '0;
    logic [DATA_W-1:0] dataDM = '0;
    logic [3:0]        be_DM  = '0;
    logic              rdy_DM;
    logic [DATA_W-1:0] outDM;
    logic              rvalid_DM;
    logic              err_DM;
    logic              busy_DM;

    int checks = 0;
    int errors = 0;

    datamem_param #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .CLEAR_ON_RST(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_DM   (req_DM),
        .we_DM    (we_DM),
        .addDM    (addDM),
        .dataDM   (dataDM),
        .be_DM    (be_DM),
        .rdy_DM   (rdy_DM),
        .outDM    (outDM),
        .rvalid_DM(rvalid_DM),
        .err_DM   (err_DM),
        .busy_DM  (busy_DM)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        req_DM = 1'b1; we_DM = 1'b1; addDM = a; dataDM = d; be_DM = be;
        cyc();
        req_DM = 1'b0; we_DM = 1'b0; be_DM = '0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                      output logic rv, output logic er);
        req_DM = 1'b1; we_DM = 1'b0; addDM = a;
        cyc();
        req_DM = 1'b0;
        cyc();
        d = outDM; rv = rvalid_DM; er = err_DM;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rdy_DM) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic rv, er; int n;
        rst_n = 1'b0;
        repeat (2) cyc();
        checks++; if ({busy_DM, rdy_DM, rvalid_DM, err_DM} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b expected 1000", {busy_DM, rdy_DM, rvalid_DM, err_DM});
        end
        checks++; if (outDM !== 32'h0) begin
            errors++; $display("FAIL reset_outDM: got %h expected 00000000", outDM);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && busy_DM; i++) begin
            n++;
            cyc();
        end
        checks++; if (n !== DEPTH) begin
            errors++; $display("FAIL sweep_len: got %0d expected %0d", n, DEPTH);
        end
        checks++; if (rdy_DM !== 1'b1) begin
            errors++; $display("FAIL rdy_after_sweep: got %b expected 1", rdy_DM);
        end
        rd(5, d, rv, er);
        checks++; if ({rv, er, d} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL cleared_read: got rv=%b er=%b d=%h expected rv=1 er=0 d=00000000", rv, er, d);
        end
        cyc();
        checks++; if (rvalid_DM !== 1'b0) begin
            errors++; $display("FAIL rvalid_strobe: got %b expected 0", rvalid_DM);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic rv, er;
        wr(0, 32'h00001DFE, 4'hF);
        req_DM = 1'b1; we_DM = 1'b0; addDM = 0;
        cyc();
        req_DM = 1'b0;
        checks++; if (rvalid_DM !== 1'b0) begin
            errors++; $display("FAIL read_latency: got rvalid %b at accept edge expected 0", rvalid_DM);
        end
        cyc();
        d = outDM; rv = rvalid_DM; er = err_DM;
        checks++; if ({rv, er, d} !== {2'b10, 32'h00001DFE}) begin
            errors++; $display("FAIL wr_then_rd: got rv=%b er=%b d=%h expected rv=1 er=0 d=00001dfe", rv, er, d);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d; logic rv, er;
        wr(1, 32'h11223344, 4'hF);
        wr(1, 32'hAABBCCDD, 4'b0101);
        rd(1, d, rv, er);
        checks++; if (d !== 32'h11BB33DD) begin
            errors++; $display("FAIL byte_lanes: got %h expected 11bb33dd", d);
        end
        wr(1, 32'hFFFFFFFF, 4'b0000);
        rd(1, d, rv, er);
        checks++; if (d !== 32'h11BB33DD) begin
            errors++; $display("FAIL be_zero_noop: got %h expected 11bb33dd", d);
        end
        wr(1, 32'h99887766, 4'b1000);
        rd(1, d, rv, er);
        checks++; if (d !== 32'h99BB33DD) begin
            errors++; $display("FAIL top_lane: got %h expected 99bb33dd", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic rv, er;
        wr(4, 32'hCAFEF00D, 4'hF);
        wr(20, 32'h12345678, 4'hF);
        checks++; if (err_DM !== 1'b0) begin
            errors++; $display("FAIL oor_wr_early: got err %b expected 0", err_DM);
        end
        cyc();
        checks++; if ({err_DM, rvalid_DM} !== 2'b10) begin
            errors++; $display("FAIL oor_wr_err: got err/rvalid %b expected 10", {err_DM, rvalid_DM});
        end
        cyc();
        checks++; if (err_DM !== 1'b0) begin
            errors++; $display("FAIL oor_wr_pulse: got err %b expected 0", err_DM);
        end
        rd(4, d, rv, er);
        checks++; if ({rv, er, d} !== {2'b10, 32'hCAFEF00D}) begin
            errors++; $display("FAIL oor_mem_intact: got rv=%b er=%b d=%h expected rv=1 er=0 d=cafef00d", rv, er, d);
        end
        rd(20, d, rv, er);
        checks++; if ({rv, er, d} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL oor_rd: got rv=%b er=%b d=%h expected rv=1 er=1 d=00000000", rv, er, d);
        end
        rd(16, d, rv, er);
        checks++; if ({rv, er, d} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL oor_rd_depth: got rv=%b er=%b d=%h expected rv=1 er=1 d=00000000", rv, er, d);
        end
        rd(15, d, rv, er);
        checks++; if ({rv, er, d} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL last_word: got rv=%b er=%b d=%h expected rv=1 er=0 d=00000000", rv, er, d);
        end
    endtask

    task automatic test_back_to_back();
        wr(0, 32'd1, 4'hF);
        wr(1, 32'd2, 4'hF);
        wr(2, 32'd3, 4'hF);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                req_DM = 1'b1; we_DM = 1'b0; addDM = ADDR_W'(i);
            end else begin
                req_DM = 1'b0;
            end
            cyc();
            if (i >= 1 && i <= 3) begin
                checks++; if ({rvalid_DM, outDM} !== {1'b1, 32'(i)}) begin
                    errors++; $display("FAIL b2b_rd%0d: got rv=%b d=%h expected rv=1 d=%h", i, rvalid_DM, outDM, 32'(i));
                end
            end else if (i == 4) begin
                checks++; if (rvalid_DM !== 1'b0) begin
                    errors++; $display("FAIL b2b_end: got rv=%b expected 0", rvalid_DM);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d; logic rv, er; bit ok;
        wr(7, 32'h5A5A5A5A, 4'hF);
        req_DM = 1'b1; we_DM = 1'b0; addDM = 7;
        cyc();
        req_DM = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({rvalid_DM, busy_DM, rdy_DM} !== 3'b010) begin
            errors++; $display("FAIL rst_mid_read: got rv/busy/rdy %b expected 010", {rvalid_DM, busy_DM, rdy_DM});
        end
        cyc();
        checks++; if (rvalid_DM !== 1'b0) begin
            errors++; $display("FAIL rst_discard: got rv=%b expected 0", rvalid_DM);
        end
        rst_n = 1'b1;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin
            errors++; $display("FAIL resweep_timeout: got rdy=%b expected 1", rdy_DM);
        end
        rd(7, d, rv, er);
        checks++; if ({rv, d} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL resweep_clear: got rv=%b d=%h expected rv=1 d=00000000", rv, d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
